booth_multiplier: RTL and testbench

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/alu_pkg.sv | 19 +
 rtl/booth_step.sv | 30 +++
 rtl/booth_multiplier.sv | 111 +++++++++++
 tb/tb_booth_multiplier.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Booth multiplier: FSM state encoding and the
// step-counter width helper used to size the iteration counter.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int BOOTH_DEFAULT_WIDTH = 8;
   localparam int BOOTH_DEFAULT_CNT_W = $clog2(BOOTH_DEFAULT_WIDTH + 1);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator followed by an arithmetic right shift of {acc,q,q_m1}.
module booth_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH:0]   m,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   output logic [WIDTH:0]   acc_nxt,
   output logic [WIDTH-1:0] q_nxt,
   output logic             q_m1_nxt
);

   logic signed [WIDTH:0] sum;

   // Recode {q[0],q_m1}, update the accumulator, then shift the triple right.
   always_comb begin
      sum = $signed(acc);
      case ({q[0], q_m1})
         2'b01:   sum = $signed(acc) + $signed(m);
         2'b10:   sum = $signed(acc) - $signed(m);
         default: sum = $signed(acc);
      endcase
      acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
      q_nxt    = {sum[0], q[WIDTH-1:1]};
      q_m1_nxt = q[0];
   end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one Booth step per clock.
// Optional feature: define BOOTH_EARLY_TERM_EN to finish a multiply by zero
// in a single cycle (IDLE straight to DONE with product 0).
module booth_multiplier
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t                state;
   // Accumulator and multiplicand carry one guard bit so -2^(WIDTH-1) never overflows.
   logic signed [WIDTH:0] acc;
   logic signed [WIDTH:0] m;
   logic [WIDTH-1:0]      q;
   logic                  q_m1;
   logic [CNT_W-1:0]      cnt;

   logic [WIDTH:0]        acc_nxt;
   logic [WIDTH-1:0]      q_nxt;
   logic                  q_m1_nxt;

   booth_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .acc      (acc),
      .m        (m),
      .q        (q),
      .q_m1     (q_m1),
      .acc_nxt  (acc_nxt),
      .q_nxt    (q_nxt),
      .q_m1_nxt (q_m1_nxt)
   );

`ifdef BOOTH_EARLY_TERM_EN
   logic zero_op;
   assign zero_op = (a == '0) || (b == '0);
`endif

   // Control FSM and datapath registers; busy/done/product are registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         m       <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
`ifdef BOOTH_EARLY_TERM_EN
                  if (zero_op) begin
                     product <= '0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else
`endif
                  begin
                     m     <= {a[WIDTH-1], a};
                     acc   <= '0;
                     q     <= b;
                     q_m1  <= 1'b0;
                     cnt   <= CNT_W'(WIDTH);
                     busy  <= 1'b1;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               acc  <= acc_nxt;
               q    <= q_nxt;
               q_m1 <= q_m1_nxt;
               cnt  <= cnt - CNT_W'(1);
               // Last step: the lower 2*WIDTH bits of the shifted {acc,q} are the product.
               if (cnt == CNT_W'(1)) begin
                  product <= {acc_nxt[WIDTH-1:0], q_nxt};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (WIDTH=8) against a plain
// arithmetic reference model; honours BOOTH_EARLY_TERM_EN when defined.
module tb_booth_multiplier;

   localparam int WIDTH = 8;
`ifdef BOOTH_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  a     = '0;
   logic [7:0]  b     = '0;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int errors = 0;
   int checks = 0;

   booth_multiplier #(
      .WIDTH(WIDTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   // Reference: exact signed product, truncated to 16 bits.
   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      int p;
      p = int'($signed(x)) * int'($signed(y));
      return p[15:0];
   endfunction

   // Negedge index (1 = first negedge after the accepting edge) at which done is seen.
   function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
      if (EARLY && (x == 8'h00 || y == 8'h00)) return 1;
      return WIDTH + 1;
   endfunction

   function automatic int ref_busy(input logic [7:0] x, input logic [7:0] y);
      if (EARLY && (x == 8'h00 || y == 8'h00)) return 0;
      return WIDTH;
   endfunction

   // Drive one start pulse in IDLE, scramble operands afterwards, wait for done.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                         output int lat, output int nbusy, output int overlap,
                         output logic [15:0] p);
      @(negedge clk);
      a = ia; b = ib; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      lat = -1; nbusy = 0; overlap = 0; p = product;
      for (int i = 1; i <= 40; i++) begin
         if (i > 1) @(negedge clk);
         if (busy && done) overlap++;
         if (busy) nbusy++;
         if (done) begin
            lat = i;
            p = product;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy, done); end
   endtask

   task automatic test_basic();
      int lat, nb, ov; logic [15:0] p;
      run_op(8'd3, 8'd5, lat, nb, ov, p);
      checks++; if (p !== 16'h000F) begin errors++; $display("FAIL basic_product: got %h expected 000F", p); end
      checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, WIDTH + 1); end
      checks++; if (nb != WIDTH) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", nb, WIDTH); end
      checks++; if (ov != 0) begin errors++; $display("FAIL basic_overlap: got %0d expected 0", ov); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got busy=%b done=%b expected 0/0", busy, done); end
      checks++; if (product !== 16'h000F) begin errors++; $display("FAIL basic_hold: got %h expected 000F", product); end
   endtask

   task automatic test_corners();
      int lat, nb, ov; logic [15:0] p;
      logic [7:0] vals [0:7];
      run_op(8'h80, 8'h80, lat, nb, ov, p);
      checks++; if (p !== 16'h4000) begin errors++; $display("FAIL min_sq: got %h expected 4000", p); end
      run_op(8'h80, 8'h7F, lat, nb, ov, p);
      checks++; if (p !== 16'hC080) begin errors++; $display("FAIL min_max: got %h expected C080", p); end
      vals[0] = 8'h80; vals[1] = 8'h81; vals[2] = 8'hFF; vals[3] = 8'h00;
      vals[4] = 8'h01; vals[5] = 8'h7F; vals[6] = 8'h02; vals[7] = 8'hFE;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            run_op(vals[i], vals[j], lat, nb, ov, p);
            checks++; if (p !== ref_mul(vals[i], vals[j])) begin errors++; $display("FAIL corner_product a=%h b=%h: got %h expected %h", vals[i], vals[j], p, ref_mul(vals[i], vals[j])); end
            checks++; if (lat != ref_lat(vals[i], vals[j])) begin errors++; $display("FAIL corner_latency a=%h b=%h: got %0d expected %0d", vals[i], vals[j], lat, ref_lat(vals[i], vals[j])); end
         end
      end
   endtask

   task automatic test_start_held();
      int lat, nb;
      @(negedge clk);
      a = 8'd7; b = 8'hFE; start = 1'b1;
      lat = -1; nb = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin lat = i; break; end
      end
      checks++; if (product !== 16'hFFF2) begin errors++; $display("FAIL held_product: got %h expected FFF2", product); end
      checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL held_latency: got %0d expected %0d", lat, WIDTH + 1); end
      checks++; if (nb != WIDTH) begin errors++; $display("FAIL held_busy_cycles: got %0d expected %0d", nb, WIDTH); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_idle_gap: got busy=%b done=%b expected 0/0", busy, done); end
      start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_no_reaccept: got busy=%b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int lat, nb, ov; logic [15:0] p;
      @(negedge clk);
      a = 8'h55; b = 8'h33; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected 0", done); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL mid_reset_product: got %h expected 0000", product); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_op(8'd2, 8'd2, lat, nb, ov, p);
      checks++; if (p !== 16'h0004) begin errors++; $display("FAIL after_reset_product: got %h expected 0004", p); end
      checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, WIDTH + 1); end
   endtask

   task automatic test_zero();
      int lat, nb, ov; logic [15:0] p;
      run_op(8'h00, 8'hFB, lat, nb, ov, p);
      checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_product: got %h expected 0000", p); end
      checks++; if (lat != ref_lat(8'h00, 8'hFB)) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, ref_lat(8'h00, 8'hFB)); end
      checks++; if (nb != ref_busy(8'h00, 8'hFB)) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected %0d", nb, ref_busy(8'h00, 8'hFB)); end
   endtask

   task automatic test_random();
      int lat, nb, ov; logic [15:0] p;
      logic [7:0] ra, rb;
      for (int n = 0; n < 2000; n++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         if (n % 50 == 0) rb = 8'h00;
         run_op(ra, rb, lat, nb, ov, p);
         checks++; if (p !== ref_mul(ra, rb)) begin errors++; $display("FAIL rand_product a=%h b=%h: got %h expected %h", ra, rb, p, ref_mul(ra, rb)); end
         checks++; if (lat != ref_lat(ra, rb)) begin errors++; $display("FAIL rand_latency a=%h b=%h: got %0d expected %0d", ra, rb, lat, ref_lat(ra, rb)); end
         checks++; if (ov != 0) begin errors++; $display("FAIL rand_overlap a=%h b=%h: got %0d expected 0", ra, rb, ov); end
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_start_held();
      test_reset_mid();
      test_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
